// File: rtl/dspba_flow_ctrl_pkg.sv
// Shared defaults, FIFO status encoding and helpers for the pipe flow controller.
// Optional feature macro used by the top: DSPBA_PIPE_FLOW_CTRL_ENA_GATE_EN.
package dspba_flow_ctrl_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_DEPTH      = 3;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } fifo_status_e;

    // Pointer widths must stay at least one bit even for a single-entry FIFO.
    function automatic int clog2_safe(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dspba_flow_fifo_ver.sv
// Register-based circular skid FIFO with show-ahead output and synchronous reset.
// Pointers wrap at FIFO_DEPTH, so the depth need not be a power of two.
module dspba_flow_fifo_ver
    import dspba_flow_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_aclr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = clog2_safe(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fifo_status_e     w_status;

    always_ff @(posedge i_clk) begin
        if (i_aclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_comb begin
        w_status = PARTIAL;
        if (r_count == '0) begin
            w_status = EMPTY;
        end else if (r_count == CNT_W'(FIFO_DEPTH)) begin
            w_status = FULL;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Credits upstream make these impossible; a hit means the credit logic is broken.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_aclr)
        !(i_push && !i_pop && (w_status == FULL)));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_aclr)
        !(i_pop && (w_status == EMPTY)));
    c_full_push_pop: cover property (@(posedge i_clk) disable iff (i_aclr)
        (w_status == FULL) && i_push && i_pop);

endmodule

// File: rtl/dspba_pipe_flow_ctrl_ver.sv
// Valid/ready flow controller around an enable-gated fixed-latency datapath.
// Define DSPBA_PIPE_FLOW_CTRL_ENA_GATE_EN to gate dp_ena off when no tokens are in flight.
module dspba_pipe_flow_ctrl_ver
    import dspba_flow_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dp_ena,
    input  logic [WIDTH-1:0] dp_xout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    logic             w_dp_ena;
    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic             w_fifo_valid;
    logic [WIDTH-1:0] w_fifo_data;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W-1:0] r_occ;

`ifdef DSPBA_PIPE_FLOW_CTRL_ENA_GATE_EN
    logic w_vld_any;
    assign w_dp_ena = !aclr && (in_valid || w_vld_any);
`else
    assign w_dp_ena = 1'b1;
`endif

    // in_ready only looks at credits; accept also needs dp_ena so a frozen datapath never takes a sample.
    assign dp_ena    = w_dp_ena;
    assign in_ready  = !aclr && (r_occ < CNT_W'(FIFO_DEPTH));
    assign w_accept  = in_valid && in_ready && w_dp_ena;
    assign out_valid = !aclr && w_fifo_valid;
    assign w_pop     = out_valid && out_ready;
    assign out_data  = w_fifo_data;
    assign occupancy = aclr ? '0 : r_occ;

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + CNT_W'(w_accept) - CNT_W'(w_pop);
        end
    end

    generate
        if (DEPTH > 0) begin : g_tokens
            logic [DEPTH-1:0] r_vld;

            always_ff @(posedge clk) begin
                if (aclr) begin
                    r_vld <= '0;
                end else if (w_dp_ena) begin
                    r_vld[0] <= w_accept;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            assign w_push = r_vld[DEPTH-1] && w_dp_ena;
`ifdef DSPBA_PIPE_FLOW_CTRL_ENA_GATE_EN
            assign w_vld_any = |r_vld;
`endif
        end else begin : g_comb
            assign w_push = w_accept;
`ifdef DSPBA_PIPE_FLOW_CTRL_ENA_GATE_EN
            assign w_vld_any = 1'b0;
`endif
        end
    endgenerate

    dspba_flow_fifo_ver #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_aclr      (aclr),
        .i_push      (w_push),
        .i_push_data (dp_xout),
        .i_pop       (w_pop),
        .o_valid     (w_fifo_valid),
        .o_data      (w_fifo_data),
        .o_count     (w_fifo_count)
    );

    a_occ_covers_fifo: assert property (@(posedge clk) disable iff (aclr)
        (r_occ >= w_fifo_count) && (r_occ <= CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_dspba_pipe_flow_ctrl_ver.sv
// Directed bench for dspba_pipe_flow_ctrl_ver (DEPTH=3/FIFO_DEPTH=4 and DEPTH=0/FIFO_DEPTH=1).
// Honours DSPBA_PIPE_FLOW_CTRL_ENA_GATE_EN when defined for the build.
module tb_dspba_pipe_flow_ctrl_ver;

    typedef struct {
        logic       inValid;
        logic       outReady;
        logic [7:0] inData;
        logic       expInReady;
        logic       expOutValid;
        logic [3:0] expOcc;
        logic [7:0] expData;
    } vec_t;

`ifdef DSPBA_PIPE_FLOW_CTRL_ENA_GATE_EN
    localparam logic RST_ENA = 1'b0;
`else
    localparam logic RST_ENA = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       aclr;
    logic       inValid, inReady, dpEna, outValid, outReady;
    logic [7:0] inData, dpXout, outData;
    logic [2:0] occupancy;
    logic       inValidZ, inReadyZ, dpEnaZ, outValidZ, outReadyZ;
    logic [7:0] inDataZ, outDataZ;
    logic [0:0] occupancyZ;
    logic [7:0] st1, st2, st3;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sent[$];
    int         modelOcc = 0;
    vec_t       stallVec[13];
    vec_t       zeroVec[6];

    always #5 clk = ~clk;

    dspba_pipe_flow_ctrl_ver #(.WIDTH(8), .DEPTH(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .aclr(aclr), .in_valid(inValid), .in_ready(inReady), .dp_ena(dpEna),
        .dp_xout(dpXout), .out_valid(outValid), .out_ready(outReady), .out_data(outData),
        .occupancy(occupancy)
    );

    dspba_pipe_flow_ctrl_ver #(.WIDTH(8), .DEPTH(0), .FIFO_DEPTH(1)) dutZero (
        .clk(clk), .aclr(aclr), .in_valid(inValidZ), .in_ready(inReadyZ), .dp_ena(dpEnaZ),
        .dp_xout(inDataZ), .out_valid(outValidZ), .out_ready(outReadyZ), .out_data(outDataZ),
        .occupancy(occupancyZ)
    );

    // Datapath model: three-stage delay line that only advances when enabled.
    always @(posedge clk) begin
        if (dpEna) begin
            st1 <= inData;
            st2 <= st1;
            st3 <= st2;
        end
    end
    assign dpXout = st3;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard for the main instance: output order and credit accounting.
    always @(negedge clk) begin
        if (aclr) begin
            sent.delete();
            modelOcc = 0;
        end else begin
            checkOutput("sb.occupancy", 32'(occupancy), modelOcc);
            checkOutput("sb.in_ready", 32'(inReady), 32'(modelOcc < 4));
            if (outValid && outReady) begin
                if (sent.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb.unexpected_output actual=%0h expected=none", outData);
                end else begin
                    checkOutput("sb.order", 32'(outData), 32'(sent.pop_front()));
                end
            end
            if (inValid && inReady) sent.push_back(inData);
            modelOcc = modelOcc + int'(inValid && inReady) - int'(outValid && outReady);
        end
    end

    function automatic vec_t mkVec(input logic iv, input logic ordy, input logic [7:0] d,
                                   input logic eir, input logic eov, input int eocc,
                                   input logic [7:0] edata);
        vec_t v;
        v.inValid = iv; v.outReady = ordy; v.inData = d;
        v.expInReady = eir; v.expOutValid = eov; v.expOcc = 4'(eocc); v.expData = edata;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input bit toZero);
        if (toZero) begin
            inValidZ = v.inValid; outReadyZ = v.outReady; inDataZ = v.inData;
        end else begin
            inValid = v.inValid; outReady = v.outReady; inData = v.inData;
        end
    endtask

    task automatic checkRow(input vec_t v, input bit toZero, input string tag);
        logic ir, ov;
        logic [7:0] od;
        logic [3:0] oc;
        ir = toZero ? inReadyZ : inReady;
        ov = toZero ? outValidZ : outValid;
        od = toZero ? outDataZ : outData;
        oc = toZero ? 4'(occupancyZ) : 4'(occupancy);
        checkOutput({tag, ".in_ready"}, 32'(ir), 32'(v.expInReady));
        checkOutput({tag, ".out_valid"}, 32'(ov), 32'(v.expOutValid));
        checkOutput({tag, ".occupancy"}, 32'(oc), 32'(v.expOcc));
        if (v.expOutValid) checkOutput({tag, ".out_data"}, 32'(od), 32'(v.expData));
    endtask

    task automatic doReset();
        aclr = 1'b1;
        @(posedge clk); #1;
        aclr = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int firstValid;
        logic acc;
        logic [4:0] enaPat;

        aclr = 1'b1;
        inValid = 0; outReady = 0; inData = 0;
        inValidZ = 0; outReadyZ = 0; inDataZ = 0;

        // Stall table: out_ready low until 4 samples are held, then drain.
        stallVec[0]  = mkVec(1, 0, 8'h01, 1, 0, 0, 8'h00);
        stallVec[1]  = mkVec(1, 0, 8'h02, 1, 0, 1, 8'h00);
        stallVec[2]  = mkVec(1, 0, 8'h03, 1, 0, 2, 8'h00);
        stallVec[3]  = mkVec(1, 0, 8'h04, 1, 0, 3, 8'h00);
        stallVec[4]  = mkVec(1, 0, 8'h05, 0, 1, 4, 8'h01);
        stallVec[5]  = mkVec(1, 0, 8'h05, 0, 1, 4, 8'h01);
        stallVec[6]  = mkVec(1, 0, 8'h05, 0, 1, 4, 8'h01);
        stallVec[7]  = mkVec(1, 0, 8'h05, 0, 1, 4, 8'h01);
        stallVec[8]  = mkVec(0, 1, 8'h05, 0, 1, 4, 8'h01);
        stallVec[9]  = mkVec(0, 1, 8'h05, 1, 1, 3, 8'h02);
        stallVec[10] = mkVec(0, 1, 8'h05, 1, 1, 2, 8'h03);
        stallVec[11] = mkVec(0, 1, 8'h05, 1, 1, 1, 8'h04);
        stallVec[12] = mkVec(0, 1, 8'h05, 1, 0, 0, 8'h00);

        // DEPTH=0 table: no same-cycle bypass, single credit.
        zeroVec[0] = mkVec(1, 1, 8'h11, 1, 0, 0, 8'h00);
        zeroVec[1] = mkVec(1, 0, 8'h22, 0, 1, 1, 8'h11);
        zeroVec[2] = mkVec(1, 1, 8'h22, 0, 1, 1, 8'h11);
        zeroVec[3] = mkVec(1, 1, 8'h22, 1, 0, 0, 8'h00);
        zeroVec[4] = mkVec(1, 1, 8'h33, 0, 1, 1, 8'h22);
        zeroVec[5] = mkVec(0, 1, 8'h33, 1, 0, 0, 8'h00);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst.in_ready", 32'(inReady), 0);
        checkOutput("rst.out_valid", 32'(outValid), 0);
        checkOutput("rst.occupancy", 32'(occupancy), 0);
        checkOutput("rst.dp_ena", 32'(dpEna), 32'(RST_ENA));
        checkOutput("rst0.in_ready", 32'(inReadyZ), 0);
        checkOutput("rst0.dp_ena", 32'(dpEnaZ), 32'(RST_ENA));
        nextCycle();
        aclr = 1'b0;

        $display("[TB] streaming with out_ready=1");
        inValid = 1; inData = 8'h01; outReady = 1;
        firstValid = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc = inValid && inReady;
            if (outValid && firstValid < 0) begin
                firstValid = c;
                checkOutput("s1.first_data", 32'(outData), 32'h01);
            end
            if (c == 4) begin
                checkOutput("s1.occ_c4", 32'(occupancy), 4);
                checkOutput("s1.in_ready_c4", 32'(inReady), 0);
            end
            nextCycle();
            if (acc) inData = inData + 8'd1;
        end
        checkOutput("s1.first_valid_cycle", firstValid, 4);
        inValid = 0;
        repeat (10) nextCycle();
        checkOutput("s1.drained", sent.size(), 0);

        $display("[TB] stall table");
        doReset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(stallVec[i], 1'b0);
            @(negedge clk);
            checkRow(stallVec[i], 1'b0, $sformatf("stall[%0d]", i));
            nextCycle();
        end

        $display("[TB] reset mid-operation");
        doReset();
        outReady = 0; inValid = 1;
        for (int c = 0; c < 4; c++) begin
            inData = 8'(8'h10 + c);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("mid.pre_occ", 32'(occupancy), 4);
        checkOutput("mid.pre_out_valid", 32'(outValid), 1);
        nextCycle();
        aclr = 1'b1;
        @(negedge clk);
        checkOutput("mid.rst_in_ready", 32'(inReady), 0);
        checkOutput("mid.rst_out_valid", 32'(outValid), 0);
        checkOutput("mid.rst_occ", 32'(occupancy), 0);
        checkOutput("mid.rst_dp_ena", 32'(dpEna), 32'(RST_ENA));
        nextCycle();
        aclr = 1'b0; inValid = 1; inData = 8'hA0; outReady = 1;
        @(negedge clk);
        checkOutput("mid.post_occ", 32'(occupancy), 0);
        checkOutput("mid.post_out_valid", 32'(outValid), 0);
        nextCycle();
        inValid = 0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("mid.no_stale_c%0d", c), 32'(outValid), 0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("mid.new_valid", 32'(outValid), 1);
        checkOutput("mid.new_data", 32'(outData), 32'hA0);
        nextCycle();

        $display("[TB] toggling out_ready under continuous input");
        doReset();
        inValid = 1; inData = 8'h80;
        for (int c = 0; c < 40; c++) begin
            outReady = c[0];
            @(negedge clk);
            acc = inValid && inReady;
            checkOutput("s4.occ_bound", 32'(occupancy <= 3'd4), 1);
            nextCycle();
            if (acc) inData = inData + 8'd1;
        end
        inValid = 0; outReady = 1;
        repeat (10) nextCycle();
        checkOutput("s4.drained", sent.size(), 0);

        $display("[TB] datapath enable and single-sample latency");
        doReset();
        inValid = 0; outReady = 1;
        repeat (3) nextCycle();
        @(negedge clk);
`ifdef DSPBA_PIPE_FLOW_CTRL_ENA_GATE_EN
        checkOutput("ena.idle", 32'(dpEna), 0);
        enaPat = 5'b01111;
`else
        checkOutput("ena.idle", 32'(dpEna), 1);
        enaPat = 5'b11111;
`endif
        nextCycle();
        inValid = 1; inData = 8'h55;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("ena.c%0d", c), 32'(dpEna), 32'(enaPat[c]));
            if (c == 4) begin
                checkOutput("ena.out_valid", 32'(outValid), 1);
                checkOutput("ena.out_data", 32'(outData), 32'h55);
            end
            nextCycle();
            inValid = 0;
        end

        $display("[TB] DEPTH=0 FIFO_DEPTH=1 table");
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(zeroVec[i], 1'b1);
            @(negedge clk);
            checkRow(zeroVec[i], 1'b1, $sformatf("zero[%0d]", i));
            nextCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
